// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- AXI-Stream to UART serialiser.
//
// Sends each accepted word as one frame:
//   start(0), d[0]..d[DWIDTH-1], tlast, parity, STOP_BITS x stop(1)
// Each bit is held for CLKS_PER_BIT uart_clk cycles. When the producer has
// another word ready in the last cycle of the last stop bit, the next start
// bit follows with no idle gap.
//
// Parameters
//   DWIDTH        data word width (>= 2)
//   PARTYP        00 even, 01 odd, 10 forced 1, 11 forced 0 (tlast excluded)
//   CLKS_PER_BIT  uart_clk cycles per bit time (>= 1)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   uart_clk       clock, rising edge
//   uart_rst_n     synchronous active-low reset
//   s_axis_tdata   word to transmit
//   s_axis_tvalid  producer has a word
//   s_axis_tlast   end-of-packet flag, sent after the data bits
//   s_axis_tready  block accepts a word this cycle
//   uart_txd       serial line, idle high, straight from a flop
//   uart_busy      high while a frame is on the line
//
// Handshake: a word transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high. tready never depends on tvalid; tdata and
// tlast are ignored on every other cycle.
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int         DWIDTH       = 8,
    parameter logic [1:0] PARTYP       = 2'b00,
    parameter int         CLKS_PER_BIT = 1,
    parameter int         STOP_BITS    = 1
) (
    input  logic              uart_clk,
    input  logic              uart_rst_n,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              uart_txd,
    output logic              uart_busy
);

    localparam int NBITS = DWIDTH + 3 + STOP_BITS;
    localparam int BCW   = $clog2(NBITS + 1);
    localparam int CCW   = $clog2(CLKS_PER_BIT + 1);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);
    localparam logic [CCW-1:0] CYC_LAST = CCW'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BCW-1:0]   bit_cnt;
    logic [CCW-1:0]   cyc_cnt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] frame_word;
    logic             par_bit;
    logic             cyc_wrap;
    logic             frame_end;
    logic             load;

    // Parity covers the data bits only.
    always_comb begin
        par_bit = 1'b0;
        case (PARTYP)
            2'b00:   par_bit = ^s_axis_tdata;
            2'b01:   par_bit = ~^s_axis_tdata;
            2'b10:   par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    // Whole frame laid out LSB-first so bit 0 is always the bit on the line.
    assign frame_word = {{STOP_BITS{1'b1}}, par_bit, s_axis_tlast, s_axis_tdata, 1'b0};

    assign cyc_wrap  = (cyc_cnt == CYC_LAST);
    assign frame_end = (state == SEND) && cyc_wrap && (bit_cnt == BIT_LAST);

    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                // Accepting in the final stop-bit cycle chains frames gap-free.
                if (frame_end) begin
                    s_axis_tready = 1'b1;
                    if (!s_axis_tvalid) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (!uart_rst_n) begin
            s_axis_tready = 1'b0;
        end
    end

    assign load = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge uart_clk) begin
        if (!uart_rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            shreg   <= '1;
        end else begin
            state <= state_next;
            if (load) begin
                shreg   <= frame_word;
                bit_cnt <= '0;
                cyc_cnt <= '0;
            end else if (state == SEND) begin
                if (cyc_wrap) begin
                    cyc_cnt <= '0;
                    // Shifting in ones leaves the line high after the last stop bit.
                    shreg   <= {1'b1, shreg[NBITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                end
            end
        end
    end

    assign uart_txd  = shreg[0];
    assign uart_busy = (state == SEND);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- bench for uart_tx.
//
// Three instances:
//   a: DWIDTH=8, even parity, 1 clk/bit, 1 stop bit
//   b: DWIDTH=8, odd parity,  1 clk/bit, 1 stop bit
//   c: DWIDTH=8, even parity, 4 clk/bit, 2 stop bits
// Expected line patterns are written first-bit-leftmost:
//   start / d0..d7 / tlast / parity / stop(s)
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    // ---------------- clock / reset ----------------
    logic uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    logic uart_rst_n;

    // ---------------- DUT a ----------------
    logic [7:0] a_tdata;
    logic       a_tvalid, a_tlast;
    logic       a_tready, a_txd, a_busy;

    uart_tx #(.DWIDTH(8), .PARTYP(2'b00), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_a (
        .uart_clk      (uart_clk),
        .uart_rst_n    (uart_rst_n),
        .s_axis_tdata  (a_tdata),
        .s_axis_tvalid (a_tvalid),
        .s_axis_tlast  (a_tlast),
        .s_axis_tready (a_tready),
        .uart_txd      (a_txd),
        .uart_busy     (a_busy)
    );

    // ---------------- DUT b ----------------
    logic [7:0] b_tdata;
    logic       b_tvalid, b_tlast;
    logic       b_tready, b_txd, b_busy;

    uart_tx #(.DWIDTH(8), .PARTYP(2'b01), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_b (
        .uart_clk      (uart_clk),
        .uart_rst_n    (uart_rst_n),
        .s_axis_tdata  (b_tdata),
        .s_axis_tvalid (b_tvalid),
        .s_axis_tlast  (b_tlast),
        .s_axis_tready (b_tready),
        .uart_txd      (b_txd),
        .uart_busy     (b_busy)
    );

    // ---------------- DUT c ----------------
    logic [7:0] c_tdata;
    logic       c_tvalid, c_tlast;
    logic       c_tready, c_txd, c_busy;

    uart_tx #(.DWIDTH(8), .PARTYP(2'b00), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_c (
        .uart_clk      (uart_clk),
        .uart_rst_n    (uart_rst_n),
        .s_axis_tdata  (c_tdata),
        .s_axis_tvalid (c_tvalid),
        .s_axis_tlast  (c_tlast),
        .s_axis_tready (c_tready),
        .uart_txd      (c_txd),
        .uart_busy     (c_busy)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         sel;    // 0 = DUT a (even), 1 = DUT b (odd)
        logic [7:0] data;
        logic       last;
        logic [11:0] seq;   // expected line, first bit in the MSB
    } vec_t;

    vec_t vecs[8];

    // Sends one word on DUT a or b starting at a falling edge with the DUT
    // idle, then checks every bit time and the return to idle. tdata/tlast
    // are scrambled right after the handshake to show they are not resampled.
    task automatic send_frame(input bit sel, input logic [7:0] data, input logic last,
                              input logic [11:0] seq, input string tag);
        logic txd, busy, rdy;
        if (sel) begin
            b_tdata = data; b_tlast = last; b_tvalid = 1'b1;
        end else begin
            a_tdata = data; a_tlast = last; a_tvalid = 1'b1;
        end
        rdy = sel ? b_tready : a_tready;
        check({tag, " tready idle"}, rdy, 1);
        @(negedge uart_clk);
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        a_tdata  = ~data; b_tdata = ~data;
        a_tlast  = ~last; b_tlast = ~last;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge uart_clk);
            txd  = sel ? b_txd   : a_txd;
            busy = sel ? b_busy  : a_busy;
            rdy  = sel ? b_tready : a_tready;
            check($sformatf("%s bit%0d txd", tag, i), txd, seq[11-i]);
            check($sformatf("%s bit%0d busy", tag, i), busy, 1);
            check($sformatf("%s bit%0d tready", tag, i), rdy, (i == 11));
        end
        @(negedge uart_clk);
        txd  = sel ? b_txd   : a_txd;
        busy = sel ? b_busy  : a_busy;
        rdy  = sel ? b_tready : a_tready;
        check({tag, " after txd"}, txd, 1);
        check({tag, " after busy"}, busy, 0);
        check({tag, " after tready"}, rdy, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [23:0] seq24;
        logic [12:0] seq13;
        logic [11:0] seq_a5;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 12'b0_1010_0101_0_0_1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 12'b0_0000_0000_0_0_1};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 12'b0_1111_1111_1_0_1};
        vecs[3] = '{1'b0, 8'h01, 1'b0, 12'b0_1000_0000_0_1_1};
        vecs[4] = '{1'b0, 8'h80, 1'b1, 12'b0_0000_0001_1_1_1};
        vecs[5] = '{1'b0, 8'h07, 1'b1, 12'b0_1110_0000_1_1_1};
        vecs[6] = '{1'b1, 8'h01, 1'b1, 12'b0_1000_0000_1_0_1};
        vecs[7] = '{1'b1, 8'h00, 1'b0, 12'b0_0000_0000_0_1_1};

        uart_rst_n = 1'b0;
        a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0;
        b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
        c_tdata = '0; c_tvalid = 1'b0; c_tlast = 1'b0;

        // Reset state.
        repeat (3) @(negedge uart_clk);
        check("rst a txd", a_txd, 1);
        check("rst a busy", a_busy, 0);
        check("rst a tready", a_tready, 0);
        check("rst b txd", b_txd, 1);
        check("rst c txd", c_txd, 1);
        check("rst c tready", c_tready, 0);
        uart_rst_n = 1'b1;

        // Idle with tvalid low.
        for (int i = 0; i < 20; i++) begin
            @(negedge uart_clk);
            check($sformatf("idle%0d txd", i), a_txd, 1);
            check($sformatf("idle%0d busy", i), a_busy, 0);
            check($sformatf("idle%0d tready", i), a_tready, 1);
        end

        // Table-driven single frames.
        for (int k = 0; k < 8; k++) begin
            send_frame(vecs[k].sel, vecs[k].data, vecs[k].last, vecs[k].seq,
                       $sformatf("vec%0d", k));
        end

        // Back-to-back 0x00 then 0xFF with tvalid held high.
        seq24 = {12'b0_0000_0000_0_0_1, 12'b0_1111_1111_0_0_1};
        a_tdata = 8'h00; a_tlast = 1'b0; a_tvalid = 1'b1;
        check("b2b tready idle", a_tready, 1);
        @(negedge uart_clk);
        a_tdata = 8'hFF;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge uart_clk);
            check($sformatf("b2b bit%0d txd", i), a_txd, seq24[23-i]);
            check($sformatf("b2b bit%0d busy", i), a_busy, 1);
            check($sformatf("b2b bit%0d tready", i), a_tready, (i == 11 || i == 23));
            if (i == 12) begin
                a_tvalid = 1'b0;
                a_tdata  = 8'h00;
            end
        end
        @(negedge uart_clk);
        check("b2b after txd", a_txd, 1);
        check("b2b after busy", a_busy, 0);

        // Slow instance: 4 clocks per bit, two stop bits, 52-cycle frame.
        seq13 = 13'b0_0011_1100_0_0_1_1;
        c_tdata = 8'h3C; c_tlast = 1'b0; c_tvalid = 1'b1;
        check("slow tready idle", c_tready, 1);
        @(negedge uart_clk);
        c_tvalid = 1'b0;
        c_tdata  = 8'hC3;
        for (int c = 0; c < 52; c++) begin
            if (c > 0) @(negedge uart_clk);
            check($sformatf("slow cyc%0d txd", c), c_txd, seq13[12 - c/4]);
            check($sformatf("slow cyc%0d busy", c), c_busy, 1);
            check($sformatf("slow cyc%0d tready", c), c_tready, (c == 51));
        end
        @(negedge uart_clk);
        check("slow after txd", c_txd, 1);
        check("slow after busy", c_busy, 0);
        check("slow after tready", c_tready, 1);

        // Reset during data bit 3 of 0xA5.
        seq_a5 = 12'b0_1010_0101_0_0_1;
        a_tdata = 8'hA5; a_tlast = 1'b0; a_tvalid = 1'b1;
        @(negedge uart_clk);
        a_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge uart_clk);
            check($sformatf("rstmid bit%0d txd", i), a_txd, seq_a5[11-i]);
            check($sformatf("rstmid bit%0d busy", i), a_busy, 1);
        end
        uart_rst_n = 1'b0;
        #1;
        check("rstmid tready in rst", a_tready, 0);
        @(negedge uart_clk);
        check("rstmid r1 txd", a_txd, 1);
        check("rstmid r1 busy", a_busy, 0);
        check("rstmid r1 tready", a_tready, 0);
        a_tdata = 8'hFF; a_tvalid = 1'b1;
        @(negedge uart_clk);
        check("rstmid r2 txd", a_txd, 1);
        check("rstmid r2 busy", a_busy, 0);
        check("rstmid r2 tready", a_tready, 0);
        a_tvalid = 1'b0;
        uart_rst_n = 1'b1;
        @(negedge uart_clk);
        check("rstmid rel txd", a_txd, 1);
        check("rstmid rel busy", a_busy, 0);
        check("rstmid rel tready", a_tready, 1);
        send_frame(1'b0, 8'h55, 1'b0, 12'b0_1010_1010_0_0_1, "post_rst55");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
